// File: rtl/apple2_video_timing_if.sv
// Purpose : bundles the soft-switch inputs and the scan timing outputs of the video timing generator.
// Latency : pure wiring, no storage.
// Backpressure: none; the timing outputs free-run and consumers sample them every cycle.
//
// Ports (master = timing generator, slave = scan-out consumer):
//   TEXT_MODE, MIXED_MODE        soft switches into the generator
//   H_COUNT[6:0], V_COUNT[8:0]   current column / line
//   HBL, VBL, COLOR_LINE         blanking and colour-kill levels
//   CPU_CE, LD_SHIFT             per-column CPU enable and shift-register load strobes
//   LINE_START, FRAME_START      first-cycle-of-line / first-cycle-of-frame strobes
interface apple2_video_timing_if;
    logic       TEXT_MODE;
    logic       MIXED_MODE;
    logic [6:0] H_COUNT;
    logic [8:0] V_COUNT;
    logic       HBL;
    logic       VBL;
    logic       COLOR_LINE;
    logic       CPU_CE;
    logic       LD_SHIFT;
    logic       LINE_START;
    logic       FRAME_START;

    modport master (
        input  TEXT_MODE, MIXED_MODE,
        output H_COUNT, V_COUNT, HBL, VBL, COLOR_LINE,
               CPU_CE, LD_SHIFT, LINE_START, FRAME_START
    );

    modport slave (
        output TEXT_MODE, MIXED_MODE,
        input  H_COUNT, V_COUNT, HBL, VBL, COLOR_LINE,
               CPU_CE, LD_SHIFT, LINE_START, FRAME_START
    );
endinterface

// File: rtl/apple2_video_timing.sv
// Purpose : Apple ][ master video scheduler: 65 columns x 14M sub-cycles (912 per line), lines, blanking, strobes.
// Latency : every output decodes registered state only; soft switches affect COLOR_LINE from the next line start.
// Backpressure: none; free-running counters, consumers must accept a strobe on the cycle it is high.
//
// Ports:
//   CLK_14M   14.31818 MHz master clock
//   RESET_N   asynchronous active-low reset
//   vid       apple2_video_timing_if.master (soft switches in, counters/blanking/strobes out)
module apple2_video_timing #(
    parameter int LINES_PER_FRAME = 262,
    parameter int ACTIVE_LINES    = 192,
    parameter int HBL_COLUMNS     = 25,
    parameter int LOAD_PHASE      = 13
) (
    input  logic                     CLK_14M,
    input  logic                     RESET_N,
    apple2_video_timing_if.master    vid
);

    localparam logic [3:0] SUB_LAST_SHORT = 4'd13;
    localparam logic [3:0] SUB_LAST_LONG  = 4'd15;
    localparam logic [6:0] H_LAST         = 7'd64;
    localparam logic [8:0] V_LAST         = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] V_ACTIVE       = 9'(ACTIVE_LINES);
    // First line of the four text rows shown at the bottom in mixed mode.
    localparam logic [8:0] V_MIXED        = 9'(ACTIVE_LINES - 32);
    localparam logic [6:0] H_HBL          = 7'(HBL_COLUMNS);
    localparam logic [3:0] SUB_LOAD       = 4'(LOAD_PHASE);

    logic [3:0] sub_q, sub_d;
    logic [6:0] h_q,   h_d;
    logic [8:0] v_q,   v_d;
    logic       color_q, color_d;
    logic       sub_last;

    // Column 64 is the long column: it absorbs the two extra 14M cycles.
    assign sub_last = (h_q == H_LAST) ? (sub_q == SUB_LAST_LONG) : (sub_q == SUB_LAST_SHORT);

    always_comb begin
        sub_d   = sub_q + 4'd1;
        h_d     = h_q;
        v_d     = v_q;
        color_d = color_q;
        if (sub_last) begin
            sub_d = 4'd0;
            if (h_q == H_LAST) begin
                h_d = 7'd0;
                v_d = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
                // Latched on the last cycle of the line, against the line about to start,
                // so the value is stable for the whole of that line.
                color_d = vid.TEXT_MODE |
                          (vid.MIXED_MODE & (v_d >= V_MIXED) & (v_d < V_ACTIVE));
            end else begin
                h_d = h_q + 7'd1;
            end
        end
    end

    always_ff @(posedge CLK_14M or negedge RESET_N) begin
        if (!RESET_N) begin
            sub_q   <= 4'd0;
            h_q     <= 7'd0;
            v_q     <= 9'd0;
            color_q <= 1'b0;
        end else begin
            sub_q   <= sub_d;
            h_q     <= h_d;
            v_q     <= v_d;
            color_q <= color_d;
        end
    end

    assign vid.H_COUNT     = h_q;
    assign vid.V_COUNT     = v_q;
    assign vid.HBL         = (h_q < H_HBL);
    assign vid.VBL         = (v_q >= V_ACTIVE);
    assign vid.COLOR_LINE  = color_q;
    assign vid.CPU_CE      = sub_last;
    // Sub-cycles 14..15 of the long column never match a phase in 0..13, so it loads once.
    assign vid.LD_SHIFT    = (sub_q == SUB_LOAD) && (h_q >= H_HBL) && (v_q < V_ACTIVE);
    assign vid.LINE_START  = (sub_q == 4'd0) && (h_q == 7'd0);
    assign vid.FRAME_START = (sub_q == 4'd0) && (h_q == 7'd0) && (v_q == 9'd0);

endmodule

// File: tb/tb_apple2_video_timing.sv
// Purpose : scoreboard bench for apple2_video_timing against a cycle-position reference model.
// Latency : expected outputs are queued as each cycle is driven and popped on the following falling edge.
// Backpressure: none; the monitor consumes one expected record per clock.
module tb_apple2_video_timing;

    localparam int LPF  = 40;
    localparam int ACT  = 36;
    localparam int HBC  = 25;
    localparam int LP   = 13;
    localparam int LINE = 912;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apple2_video_timing_if vif();

    apple2_video_timing #(
        .LINES_PER_FRAME(LPF),
        .ACTIVE_LINES   (ACT),
        .HBL_COLUMNS    (HBC),
        .LOAD_PHASE     (LP)
    ) dut (
        .CLK_14M(clk),
        .RESET_N(rst_n),
        .vid    (vif)
    );

    typedef struct packed {
        logic [6:0] h;
        logic [8:0] v;
        logic hbl, vbl, color, ce, ld, ls, fs;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   t     = 0;           // cycles since reset release
    bit   model_color = 1'b0;
    bit   cur_text = 1'b0, cur_mixed = 1'b0;
    bit   started = 1'b0;
    bit   rt = 1'b0, rm = 1'b0;

    // Reference: everything derived from the position of cycle tt within line and frame.
    function automatic exp_t model(input int tt, input bit col);
        exp_t e;
        int line, pos, v, h, sub;
        line = tt / LINE;
        pos  = tt % LINE;
        v    = line % LPF;
        if (pos < 64 * 14) begin
            h = pos / 14; sub = pos % 14;
        end else begin
            h = 64; sub = pos - 64 * 14;
        end
        e.h     = 7'(h);
        e.v     = 9'(v);
        e.hbl   = (pos < HBC * 14);
        e.vbl   = (v >= ACT);
        e.color = col;
        e.ce    = (pos < 64 * 14) ? (sub == 13) : (pos == LINE - 1);
        e.ld    = (sub == LP) && (h >= HBC) && (v < ACT);
        e.ls    = (pos == 0);
        e.fs    = ((tt % (LINE * LPF)) == 0);
        return e;
    endfunction

    function automatic bit color_rule(input bit tx, input bit mx, input int v);
        return tx | (mx && (v >= ACT - 32) && (v < ACT));
    endfunction

    // One clock: advance the model on the edge, then drive the inputs for the coming cycle.
    task automatic tick(input bit rn, input bit txt, input bit mix);
        @(posedge clk);
        if (rst_n) begin
            t++;
            if (t % LINE == 0)
                model_color = color_rule(cur_text, cur_mixed, (t / LINE) % LPF);
        end
        #2;
        vif.TEXT_MODE  = txt;
        vif.MIXED_MODE = mix;
        cur_text  = txt;
        cur_mixed = mix;
        if (!rn) begin
            rst_n       = 1'b0;
            t           = 0;
            model_color = 1'b0;
        end else begin
            rst_n = 1'b1;
        end
        q.push_back(model(t, model_color));
        started = 1'b1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    // Per-line statistics gathered from the DUT outputs.
    int period, ce_cnt, g16, badgap, hbl_cnt, ld_cnt, first_ld, since_ce, line_v;
    bit in_line = 1'b0, ce_seen = 1'b0;

    task automatic check_line();
        chk("line_period", period, LINE);
        chk("ce_count", ce_cnt, 65);
        chk("ce_gap16", g16, 1);
        chk("ce_badgap", badgap, 0);
        chk("hbl_cycles", hbl_cnt, 350);
        chk("ld_count", ld_cnt, (line_v < ACT) ? 40 : 0);
        if (line_v < ACT) chk("ld_first", first_ld, HBC * 14 + LP);
    endtask

    exp_t e, got;
    always @(negedge clk) begin
        if (started) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty got=0 want>=1 at %0t", $time);
            end else begin
                e   = q.pop_front();
                got = '{h: vif.H_COUNT, v: vif.V_COUNT, hbl: vif.HBL, vbl: vif.VBL,
                        color: vif.COLOR_LINE, ce: vif.CPU_CE, ld: vif.LD_SHIFT,
                        ls: vif.LINE_START, fs: vif.FRAME_START};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL cycle at %0t got h=%0d v=%0d hbl=%b vbl=%b col=%b ce=%b ld=%b ls=%b fs=%b want h=%0d v=%0d hbl=%b vbl=%b col=%b ce=%b ld=%b ls=%b fs=%b",
                             $time, got.h, got.v, got.hbl, got.vbl, got.color, got.ce, got.ld, got.ls, got.fs,
                             e.h, e.v, e.hbl, e.vbl, e.color, e.ce, e.ld, e.ls, e.fs);
                end
                if (!rst_n) begin
                    in_line = 1'b0;
                    ce_seen = 1'b0;
                end else begin
                    if (got.ls) begin
                        if (in_line) check_line();
                        in_line = 1'b1; period = 0; ce_cnt = 0; g16 = 0; badgap = 0;
                        hbl_cnt = 0; ld_cnt = 0; first_ld = -1; line_v = int'(e.v);
                    end
                    if (in_line) begin
                        if (got.ce) begin
                            ce_cnt++;
                            if (ce_seen) begin
                                if (since_ce == 16) g16++;
                                else if (since_ce != 14) badgap++;
                            end
                            ce_seen  = 1'b1;
                            since_ce = 0;
                        end
                        if (got.hbl) hbl_cnt++;
                        if (got.ld) begin
                            if (first_ld < 0) first_ld = period;
                            ld_cnt++;
                        end
                        period++;
                        since_ce++;
                    end
                end
            end
        end
    end

    initial begin
        int n;
        vif.TEXT_MODE  = 1'b0;
        vif.MIXED_MODE = 1'b0;

        // Reset held for 10 cycles.
        repeat (10) tick(1'b0, 1'b0, 1'b0);

        // Run into line 10, column 40 in mixed mode, then reset mid-frame.
        n = 0;
        while (t != 10 * LINE + 40 * 14 && n < 20 * LINE) begin
            tick(1'b1, 1'b0, 1'b1);
            n++;
        end
        repeat (6) tick(1'b0, 1'b0, 1'b1);

        // Full frame plus two lines: graphics with mixed text rows, covers VBL and wrap.
        repeat (LPF * LINE + 2 * LINE) tick(1'b1, 1'b0, 1'b1);

        // TEXT_MODE rises at column 30; COLOR_LINE must wait for the next line.
        n = 0;
        while (t % LINE != 30 * 14 && n < 2 * LINE) begin
            tick(1'b1, 1'b0, 1'b0);
            n++;
        end
        repeat (2 * LINE) tick(1'b1, 1'b1, 1'b0);

        // Random soft-switch activity.
        rt = 1'b0; rm = 1'b0;
        repeat (8 * LINE) begin
            if ($urandom_range(0, 299) == 0) rt = ~rt;
            if ($urandom_range(0, 299) == 0) rm = ~rm;
            tick(1'b1, rt, rm);
        end

        // TEXT_MODE forces colour kill on every line regardless of MIXED_MODE.
        repeat (3 * LINE) tick(1'b1, 1'b1, 1'($urandom_range(0, 1)));

        @(negedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
